// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one sram-like memory port between the fetch master (read-only)
//   and the load/store master. Requests pass through combinationally with
//   data-side priority. A request that is presented but not yet accepted
//   locks the port to its master until mem_addr_ok. Every accepted request
//   pushes its owner id into a small in-order FIFO, so each mem_data_ok and
//   mem_rdata can be steered back to the master that issued the request.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_*                      fetch master (req/addr in, addr_ok/data_ok/rdata out)
//   data_*                      load/store master (req/wr/size/wstrb/addr/wdata in,
//                               addr_ok/data_ok/rdata out)
//   mem_*                       shared memory port (req/wr/size/wstrb/addr/wdata out,
//                               addr_ok/data_ok/rdata in)
//
// Parameter
//   DEPTH   max outstanding accepted requests awaiting data_ok (power of 2, >= 2)

module sram_bus_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    // fetch master
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store master
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // memory port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    // state
    logic             lock_q, lock_d;
    logic             lock_owner_q, lock_owner_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // combinational helpers
    logic     owner;
    logic     owner_req;
    logic     empty;
    logic     full;
    logic     accept;
    logic     pop;
    logic     head;
    mem_cmd_t cmd;

    // ------------------------------------------------------------------
    // Grant and request mux
    // ------------------------------------------------------------------
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);

        // A pending (presented but not accepted) request keeps the port,
        // so the memory sees a stable command until it takes it.
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (data_req) begin
            owner = OWN_DATA;
        end else begin
            owner = OWN_INST;
        end

        owner_req = (owner == OWN_DATA) ? data_req : inst_req;

        // resetn gates the request so nothing leaks out while reset is held.
        mem_req = resetn & owner_req & ~full;
        accept  = mem_req & mem_addr_ok;

        inst_addr_ok = accept & (owner == OWN_INST);
        data_addr_ok = accept & (owner == OWN_DATA);

        if (owner == OWN_DATA) begin
            cmd.wr    = data_wr;
            cmd.size  = data_size;
            cmd.wstrb = data_wstrb;
            cmd.addr  = data_addr;
            cmd.wdata = data_wdata;
        end else begin
            cmd.wr    = 1'b0;
            cmd.size  = 2'd2;
            cmd.wstrb = 4'h0;
            cmd.addr  = inst_addr;
            cmd.wdata = 32'h0;
        end

        mem_wr    = cmd.wr;
        mem_size  = cmd.size;
        mem_wstrb = cmd.wstrb;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;
    end

    // ------------------------------------------------------------------
    // Response routing: the FIFO head names the owner of the oldest
    // outstanding request. A data_ok with nothing outstanding is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        head         = fifo_q[rd_ptr_q];
        pop          = resetn & mem_data_ok & ~empty;
        inst_data_ok = pop & (head == OWN_INST);
        data_data_ok = pop & (head == OWN_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;

        // mem_req is 0 when full, so a full FIFO leaves the lock untouched.
        if (mem_req) begin
            if (mem_addr_ok) begin
                lock_d = 1'b0;
            end else begin
                lock_d       = 1'b1;
                lock_owner_d = owner;
            end
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = owner;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_INST;
            fifo_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule
